// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - pipeline performance counters with cycle-limit halt and registered read port
module perf_monitor #(
  parameter int unsigned CYCLE_LIMIT = 30,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             branch_eq_i,
  input  logic [31:0]      pc_i,
  input  logic             clr_i,
  input  logic             rd_req_i,
  input  logic [2:0]       rd_addr_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             halt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [31:0]      last_pc;
  logic [CNT_W-1:0] cycle_inc, stall_inc, flush_inc;
  logic [CNT_W-1:0] rd_mux;
  logic             stall_hit, flush_hit, limit_hit;

  // A stall is only counted when no redirect is decoded in the same cycle
  assign stall_hit = stall_i & ~jump_i & ~branch_i;
  assign flush_hit = (branch_i & branch_eq_i) | jump_i;

  // Saturating increments: counters stick at all-ones instead of wrapping
  assign cycle_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
  assign stall_inc = (&stall_cnt) ? stall_cnt : stall_cnt + CNT_W'(1);
  assign flush_inc = (&flush_cnt) ? flush_cnt : flush_cnt + CNT_W'(1);

  // Compare in a widened domain so a narrow counter can never alias the limit
  assign limit_hit = ({{32{1'b0}}, cycle_inc} == {{CNT_W{1'b0}}, CYCLE_LIMIT});

  // Next-state logic; clear overrides everything and returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN: begin
        if (limit_hit)     state_nxt = HALT;
        else if (!start_i) state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    if (clr_i) state_nxt = IDLE;
  end

  // State register and registered halt flag tracking the HALT state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      halt_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      halt_o <= (state_nxt == HALT);
    end
  end

  // Event counters and last PC: advance only while running, clear has priority
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      last_pc   <= '0;
    end else if (clr_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      last_pc   <= '0;
    end else if (state == RUN) begin
      cycle_cnt <= cycle_inc;
      if (stall_hit) stall_cnt <= stall_inc;
      if (flush_hit) flush_cnt <= flush_inc;
      last_pc <= pc_i;
    end
  end

  // Read mux over the current (pre-update) register values
  always_comb begin
    rd_mux = '0;
    case (rd_addr_i)
      3'd0:    rd_mux = cycle_cnt;
      3'd1:    rd_mux = stall_cnt;
      3'd2:    rd_mux = flush_cnt;
      3'd3:    rd_mux = CNT_W'(last_pc);
      3'd4:    rd_mux = CNT_W'({halt_o, state == RUN, state == IDLE});
      default: rd_mux = '0;
    endcase
  end

  // One-cycle read response; data holds between requests
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - scoreboard bench for perf_monitor
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        rst, start, stall, jump, branch, branch_eq, clr;
  logic        rd_req, rd_req4;
  logic [2:0]  rd_addr;
  logic [31:0] pc;
  logic [31:0] rd_data;
  logic        rd_valid, halt;
  logic [3:0]  rd_data4;
  logic        rd_valid4, halt4;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp4_q[$];
  logic [31:0] e_main, e_small;

  always #5 clk = ~clk;

  perf_monitor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .jump_i(jump),
    .branch_i(branch), .branch_eq_i(branch_eq), .pc_i(pc), .clr_i(clr),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .halt_o(halt)
  );

  perf_monitor #(.CYCLE_LIMIT(20), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .jump_i(jump),
    .branch_i(branch), .branch_eq_i(branch_eq), .pc_i(pc), .clr_i(clr),
    .rd_req_i(rd_req4), .rd_addr_i(rd_addr), .rd_data_o(rd_data4),
    .rd_valid_o(rd_valid4), .halt_o(halt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    rd_addr = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic rd4(input logic [2:0] a, input logic [31:0] e);
    rd_addr = a;
    rd_req4 = 1'b1;
    exp4_q.push_back(e);
    @(negedge clk);
    rd_req4 = 1'b0;
  endtask

  // Scoreboard monitor for the default-parameter instance
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e_main = exp_q.pop_front();
        check("rd_data", rd_data, e_main);
      end
    end
  end

  // Scoreboard monitor for the narrow-counter instance
  always @(negedge clk) begin
    if (rd_valid4) begin
      if (exp4_q.size() == 0) begin
        check("rd4_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e_small = exp4_q.pop_front();
        check("rd4_data", {28'd0, rd_data4}, e_small);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 0; stall = 0; jump = 0; branch = 0; branch_eq = 0;
    clr = 0; rd_req = 0; rd_req4 = 0; rd_addr = 0; pc = 0;
    #1;
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_halt", {31'd0, halt}, 32'd0);
    step(2);
    rst = 1'b0;

    // Run to the cycle limit; narrow instance saturates alongside
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 30) check("halt_before_limit", {31'd0, halt}, 32'd0);
      if (i == 31) check("halt_at_limit", {31'd0, halt}, 32'd1);
      if (i == 40) begin
        check("halt_held", {31'd0, halt}, 32'd1);
        check("halt4_never", {31'd0, halt4}, 32'd0);
      end
    end
    start = 1'b0;
    rd(3'd0, 32'd30);
    rd(3'd4, 32'd4);
    step(3);
    rd(3'd0, 32'd30);
    rd4(3'd0, 32'd15);
    rd4(3'd4, 32'd1);
    clr = 1'b1;
    rd(3'd0, 32'd30);
    clr = 1'b0;
    check("halt_after_clr", {31'd0, halt}, 32'd0);
    rd(3'd0, 32'd0);
    rd(3'd4, 32'd1);

    // Stall / flush accounting
    start = 1'b1;
    step(1);
    stall = 1'b1;
    step(3);
    jump = 1'b1;
    step(1);
    stall = 0; jump = 0; branch = 1; branch_eq = 1;
    step(2);
    branch = 0; branch_eq = 0;
    rd(3'd1, 32'd3);
    rd(3'd0, 32'd7);
    check("rd_valid_pulse_high", {31'd0, rd_valid}, 32'd1);
    step(1);
    check("rd_valid_pulse_low", {31'd0, rd_valid}, 32'd0);
    rd(3'd2, 32'd3);
    rd(3'd4, 32'd2);

    // Not-taken branches count nothing; last_pc tracks pc
    start = 1'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    start = 1'b1;
    step(1);
    branch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h1000 + 32'(i * 4);
      step(1);
    end
    branch = 1'b0;
    rd(3'd2, 32'd0);
    rd(3'd1, 32'd0);
    rd(3'd0, 32'd7);
    rd(3'd3, 32'h1010);

    // Asynchronous reset mid-run
    start = 1'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    start = 1'b1;
    step(1);
    step(11);
    rd(3'd0, 32'd11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rd_data", rd_data, 32'd0);
    check("async_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("async_rst_halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    rd(3'd4, 32'd1);
    rd(3'd0, 32'd0);
    rd(3'd3, 32'd0);

    step(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("scoreboard4_drained", 32'(exp4_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
